// File: rtl/motor_pkg.sv
// Shared definitions for the motor PWM scheduler.
//   SPEED_W      width of one channel's speed word
//   state_e      scheduler state encoding (also driven onto the o_state port)
//   clamp_speed  saturates a 17-bit value into [lo, hi] and returns a speed word
package motor_pkg;

   localparam int unsigned SPEED_W = 16;

   typedef enum logic [1:0] {
      StIdle   = 2'b00,
      StArming = 2'b01,
      StRun    = 2'b10,
      StFault  = 2'b11
   } state_e;

   function automatic logic [SPEED_W-1:0] clamp_speed(input logic [SPEED_W:0] val,
                                                      input logic [SPEED_W:0] lo,
                                                      input logic [SPEED_W:0] hi);
      logic [SPEED_W:0] w_res;
      if (val < lo) begin
         w_res = lo;
      end else if (val > hi) begin
         w_res = hi;
      end else begin
         w_res = val;
      end
      return w_res[SPEED_W-1:0];
   endfunction

endpackage

// File: rtl/motor_slew_step.sv
// One channel's rate-limited next speed value (purely combinational).
//   i_cur     current speed word
//   i_target  target speed word
//   i_step    largest allowed |change| per update
//   i_min     lower saturation bound
//   i_max     upper saturation bound
//   o_next    next speed word, moved toward the target and saturated into [i_min, i_max]
module motor_slew_step
   import motor_pkg::*;
(
   input  logic [SPEED_W-1:0] i_cur,
   input  logic [SPEED_W-1:0] i_target,
   input  logic [SPEED_W:0]   i_step,
   input  logic [SPEED_W:0]   i_min,
   input  logic [SPEED_W:0]   i_max,
   output logic [SPEED_W-1:0] o_next
);

   logic [SPEED_W:0] w_cur;
   logic [SPEED_W:0] w_tgt;
   logic [SPEED_W:0] w_diff;
   logic [SPEED_W:0] w_sum;

   // 17-bit arithmetic so cur + step can never wrap before saturation.
   always_comb begin
      w_cur  = {1'b0, i_cur};
      w_tgt  = {1'b0, i_target};
      w_diff = '0;
      w_sum  = w_cur;
      if (w_tgt > w_cur) begin
         w_diff = w_tgt - w_cur;
         w_sum  = w_cur + ((w_diff < i_step) ? w_diff : i_step);
      end else if (w_tgt < w_cur) begin
         w_diff = w_cur - w_tgt;
         w_sum  = w_cur - ((w_diff < i_step) ? w_diff : i_step);
      end
      o_next = clamp_speed(w_sum, i_min, i_max);
   end

endmodule

// File: rtl/motor_pwm_sched.sv
// Quadcopter motor PWM scheduler: arming sequence, slew-limited speed updates on a fixed
// update tick, and a command-loss failsafe.
//   clk, rst_n     clock, asynchronous active-low reset
//   i_arm_req      level; leave IDLE for ARMING
//   i_disarm_req   level; return to IDLE from any state (wins over arm)
//   i_cmd_valid    speed command valid; accepted only while o_cmd_ready
//   o_cmd_ready    high in RUN
//   i_cmd_speed    target speeds, motor i in bits [16*i+15:16*i]
//   o_speed_out    registered speed words, updated only on a tick
//   o_speed_oe     one-cycle load strobe coincident with each speed_out update
//   o_state        00 IDLE, 01 ARMING, 10 RUN, 11 FAULT
//   o_fault        high while in FAULT
module motor_pwm_sched
   import motor_pkg::*;
#(
   parameter int unsigned NUM_MOTORS    = 4,
   parameter int unsigned MIN_SPEED     = 256,
   parameter int unsigned MAX_SPEED     = 65535,
   parameter int unsigned UPDATE_PERIOD = 65536,
   parameter int unsigned ARM_TICKS     = 50,
   parameter int unsigned SLEW_STEP     = 512,
   parameter int unsigned TIMEOUT_TICKS = 20
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          i_arm_req,
   input  logic                          i_disarm_req,
   input  logic                          i_cmd_valid,
   output logic                          o_cmd_ready,
   input  logic [SPEED_W*NUM_MOTORS-1:0] i_cmd_speed,
   output logic [SPEED_W*NUM_MOTORS-1:0] o_speed_out,
   output logic                          o_speed_oe,
   output logic [1:0]                    o_state,
   output logic                          o_fault
);

   localparam int unsigned CNT_W = $clog2(UPDATE_PERIOD);
   localparam int unsigned ARM_W = $clog2(ARM_TICKS + 1);
   localparam int unsigned TO_W  = $clog2(TIMEOUT_TICKS + 1);

   localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(UPDATE_PERIOD - 1);
   localparam logic [ARM_W-1:0]   ARM_LAST  = ARM_W'(ARM_TICKS);
   localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT_TICKS);
   localparam logic [SPEED_W:0]   MIN_17    = (SPEED_W + 1)'(MIN_SPEED);
   localparam logic [SPEED_W:0]   MAX_17    = (SPEED_W + 1)'(MAX_SPEED);
   localparam logic [SPEED_W:0]   STEP_17   = (SPEED_W + 1)'(SLEW_STEP);
   localparam logic [SPEED_W-1:0] MIN_16    = SPEED_W'(MIN_SPEED);

   state_e                              r_state, w_state_d;
   logic [CNT_W-1:0]                    r_tick_cnt;
   logic [ARM_W-1:0]                    r_arm_cnt, w_arm_cnt_d, w_arm_inc;
   logic [TO_W-1:0]                     r_to_cnt, w_to_cnt_d, w_to_inc;
   logic [NUM_MOTORS-1:0][SPEED_W-1:0]  r_target, w_target_d;
   logic [NUM_MOTORS-1:0][SPEED_W-1:0]  r_speed, w_speed_d;
   logic [NUM_MOTORS-1:0][SPEED_W-1:0]  w_slew;
   logic                                r_speed_oe;
   logic                                w_tick;
   logic                                w_accept;

   // Free-running update tick; never resynchronised to the FSM.
   assign w_tick = (r_tick_cnt == TICK_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CNT_W'(1);
      end
   end

   for (genvar g = 0; g < int'(NUM_MOTORS); g++) begin : g_slew
      motor_slew_step u_slew (
         .i_cur    (r_speed[g]),
         .i_target (r_target[g]),
         .i_step   (STEP_17),
         .i_min    (MIN_17),
         .i_max    (MAX_17),
         .o_next   (w_slew[g])
      );
   end

   assign w_accept  = i_cmd_valid && (r_state == StRun);
   assign w_arm_inc = r_arm_cnt + ARM_W'(1);
   assign w_to_inc  = r_to_cnt + TO_W'(1);

   always_comb begin
      w_state_d   = r_state;
      w_arm_cnt_d = r_arm_cnt;
      w_to_cnt_d  = r_to_cnt;
      w_target_d  = r_target;
      w_speed_d   = r_speed;
      if (i_disarm_req) begin
         w_state_d   = StIdle;
         w_arm_cnt_d = '0;
         w_to_cnt_d  = '0;
         w_target_d  = '0;
         if (w_tick) w_speed_d = '0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_tick) w_speed_d = '0;
               if (i_arm_req) begin
                  w_state_d   = StArming;
                  w_arm_cnt_d = '0;
               end
            end
            StArming: begin
               if (w_tick) begin
                  for (int i = 0; i < int'(NUM_MOTORS); i++) w_speed_d[i] = MIN_16;
                  w_arm_cnt_d = w_arm_inc;
                  if (w_arm_inc == ARM_LAST) begin
                     w_state_d  = StRun;
                     w_to_cnt_d = '0;
                     for (int i = 0; i < int'(NUM_MOTORS); i++) w_target_d[i] = MIN_16;
                  end
               end
            end
            StRun: begin
               // The tick slews toward the target held before any same-cycle accept.
               if (w_tick) w_speed_d = w_slew;
               if (w_accept) begin
                  w_to_cnt_d = '0;
                  for (int i = 0; i < int'(NUM_MOTORS); i++) begin
                     w_target_d[i] = clamp_speed({1'b0, i_cmd_speed[SPEED_W*i +: SPEED_W]},
                                                 MIN_17, MAX_17);
                  end
               end else if (w_tick) begin
                  w_to_cnt_d = w_to_inc;
                  if (w_to_inc == TO_LAST) w_state_d = StFault;
               end
            end
            StFault: begin
               if (w_tick) w_speed_d = '0;
            end
            default: w_state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_arm_cnt  <= '0;
         r_to_cnt   <= '0;
         r_target   <= '0;
         r_speed    <= '0;
         r_speed_oe <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_arm_cnt  <= w_arm_cnt_d;
         r_to_cnt   <= w_to_cnt_d;
         r_target   <= w_target_d;
         r_speed    <= w_speed_d;
         r_speed_oe <= w_tick;
      end
   end

   assign o_speed_out = r_speed;
   assign o_speed_oe  = r_speed_oe;
   assign o_state     = r_state;
   assign o_fault     = (r_state == StFault);
   assign o_cmd_ready = (r_state == StRun);

endmodule

// File: tb/tb_motor_pwm_sched.sv
// Bench for motor_pwm_sched: a behavioural model checked every cycle, plus directed literals.
module tb_motor_pwm_sched;

   localparam int NM     = 4;
   localparam int PERIOD = 8;
   localparam int ARM    = 3;
   localparam int STEP   = 100;
   localparam int TO     = 4;
   localparam int MINS   = 256;
   localparam int MAXS   = 4000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        arm_req, disarm_req, cmd_valid;
   logic [63:0] cmd_speed;
   logic        o_cmd_ready, o_speed_oe, o_fault;
   logic [63:0] o_speed_out;
   logic [1:0]  o_state;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   motor_pwm_sched #(
      .NUM_MOTORS    (NM),
      .MIN_SPEED     (MINS),
      .MAX_SPEED     (MAXS),
      .UPDATE_PERIOD (PERIOD),
      .ARM_TICKS     (ARM),
      .SLEW_STEP     (STEP),
      .TIMEOUT_TICKS (TO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_arm_req    (arm_req),
      .i_disarm_req (disarm_req),
      .i_cmd_valid  (cmd_valid),
      .o_cmd_ready  (o_cmd_ready),
      .i_cmd_speed  (cmd_speed),
      .o_speed_out  (o_speed_out),
      .o_speed_oe   (o_speed_oe),
      .o_state      (o_state),
      .o_fault      (o_fault)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] spd4(input int m3, input int m2, input int m1, input int m0);
      return {m3[15:0], m2[15:0], m1[15:0], m0[15:0]};
   endfunction

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   // ---------------- behavioural model ----------------
   // States as plain integers 0..3; outputs, targets as integer arrays.
   int m_edges = 0;
   int m_state = 0;
   int m_arm   = 0;
   int m_to    = 0;
   int m_out[NM];
   int m_tgt[NM];
   bit m_oe    = 0;
   bit m_tick, m_acc;

   task automatic model_reset();
      m_edges = 0; m_state = 0; m_arm = 0; m_to = 0; m_oe = 0;
      for (int i = 0; i < NM; i++) begin m_out[i] = 0; m_tgt[i] = 0; end
   endtask

   task automatic model_step();
      int d;
      m_tick  = (m_edges % PERIOD) == PERIOD - 1;
      m_edges = m_edges + 1;
      m_acc   = cmd_valid && (m_state == 2);
      m_oe    = m_tick;
      if (disarm_req) begin
         m_state = 0; m_arm = 0; m_to = 0;
         for (int i = 0; i < NM; i++) begin
            m_tgt[i] = 0;
            if (m_tick) m_out[i] = 0;
         end
      end else if (m_state == 0) begin
         if (m_tick) for (int i = 0; i < NM; i++) m_out[i] = 0;
         if (arm_req) begin m_state = 1; m_arm = 0; end
      end else if (m_state == 1) begin
         if (m_tick) begin
            for (int i = 0; i < NM; i++) m_out[i] = MINS;
            m_arm = m_arm + 1;
            if (m_arm == ARM) begin
               m_state = 2; m_to = 0;
               for (int i = 0; i < NM; i++) m_tgt[i] = MINS;
            end
         end
      end else if (m_state == 2) begin
         if (m_tick) begin
            for (int i = 0; i < NM; i++) begin
               d = m_tgt[i] - m_out[i];
               if (d > STEP) d = STEP;
               if (d < -STEP) d = -STEP;
               m_out[i] = clampi(m_out[i] + d, MINS, MAXS);
            end
         end
         if (m_acc) begin
            m_to = 0;
            for (int i = 0; i < NM; i++) m_tgt[i] = clampi(int'(cmd_speed[16*i +: 16]), MINS, MAXS);
         end else if (m_tick) begin
            m_to = m_to + 1;
            if (m_to == TO) m_state = 3;
         end
      end else begin
         if (m_tick) for (int i = 0; i < NM; i++) m_out[i] = 0;
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // Compare DUT against the model 1 time unit after every rising edge.
   initial begin
      logic [63:0] exp;
      forever begin
         @(posedge clk);
         #1;
         exp = '0;
         for (int i = 0; i < NM; i++) exp[16*i +: 16] = m_out[i][15:0];
         check("model_speed_out", o_speed_out, exp);
         check("model_speed_oe", o_speed_oe, m_oe);
         check("model_state", o_state, m_state[1:0]);
         check("model_fault", o_fault, m_state == 3);
         check("model_cmd_ready", o_cmd_ready, m_state == 2);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic wait_strobe(output int n);
      bit seen;
      seen = 0;
      n = 0;
      while (!seen && n < 40) begin
         @(posedge clk);
         #1;
         n++;
         seen = o_speed_oe;
      end
      if (!seen) begin
         n_checks++;
         n_errors++;
         $display("FAIL strobe_wait: no speed_oe within %0d cycles, required one", n);
      end
   endtask

   task automatic pulse_cmd(input logic [63:0] spd);
      cmd_speed = spd;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic pulse_arm();
      arm_req = 1'b1;
      @(posedge clk);
      #1;
      arm_req = 1'b0;
   endtask

   task automatic pulse_disarm();
      disarm_req = 1'b1;
      @(posedge clk);
      #1;
      disarm_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      logic [63:0] cmd;
      logic [63:0] ramp_exp[4];
      ramp_exp[0] = spd4(300, 256, 356, 356);
      ramp_exp[1] = spd4(300, 256, 456, 456);
      ramp_exp[2] = spd4(300, 256, 556, 556);
      ramp_exp[3] = spd4(300, 256, 656, 600);

      rst_n = 1'b0; arm_req = 1'b0; disarm_req = 1'b0; cmd_valid = 1'b0; cmd_speed = '0;
      @(posedge clk);
      #1;
      check("rst_speed_out", o_speed_out, 64'd0);
      check("rst_state", o_state, 2'b00);
      check("rst_oe", o_speed_oe, 1'b0);
      check("rst_ready", o_cmd_ready, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Idle strobes every PERIOD cycles with zero output.
      for (int k = 0; k < 3; k++) begin
         wait_strobe(n);
         check("idle_period", n, 8);
         check("idle_out", o_speed_out, 64'd0);
         check("idle_ready", o_cmd_ready, 1'b0);
      end

      // Arming: three strobes at MIN_SPEED, then RUN.
      pulse_arm();
      check("arming_state", o_state, 2'b01);
      for (int k = 0; k < 3; k++) begin
         wait_strobe(n);
         check("arm_out", o_speed_out, {4{16'd256}});
      end
      check("run_state", o_state, 2'b10);
      check("run_ready", o_cmd_ready, 1'b1);

      // Ramp with clamping: m0=600, m1=5000 (->4000), m2=0 (->256), m3=300.
      cmd = spd4(300, 0, 5000, 600);
      for (int k = 0; k < 4; k++) begin
         pulse_cmd(cmd);
         wait_strobe(n);
         check("ramp", o_speed_out, ramp_exp[k]);
      end
      for (int k = 0; k < 35; k++) begin
         pulse_cmd(cmd);
         wait_strobe(n);
      end
      check("clamp_max", o_speed_out, spd4(300, 256, 4000, 600));

      // Command loss: the tick after the last accept already counted one, so FAULT on the 3rd.
      wait_strobe(n);
      wait_strobe(n);
      check("timeout_not_yet", o_state, 2'b10);
      wait_strobe(n);
      check("timeout_state", o_state, 2'b11);
      check("timeout_fault", o_fault, 1'b1);
      check("timeout_hold", o_speed_out, spd4(300, 256, 4000, 600));
      check("fault_ready", o_cmd_ready, 1'b0);
      pulse_cmd(spd4(1000, 1000, 1000, 1000));
      wait_strobe(n);
      check("fault_cut", o_speed_out, 64'd0);
      check("fault_stays", o_state, 2'b11);
      pulse_disarm();
      check("disarm_from_fault", o_state, 2'b00);
      check("disarm_fault_clr", o_fault, 1'b0);

      // Arm and disarm together: disarm wins.
      arm_req = 1'b1;
      disarm_req = 1'b1;
      @(posedge clk);
      #1;
      arm_req = 1'b0;
      disarm_req = 1'b0;
      check("arm_disarm_idle", o_state, 2'b00);

      // Disarm mid-ramp.
      pulse_arm();
      check("rearm_state", o_state, 2'b01);
      for (int k = 0; k < 3; k++) wait_strobe(n);
      check("rearm_run", o_state, 2'b10);
      pulse_cmd(spd4(0, 0, 0, 4000));
      wait_strobe(n);
      check("ramp2", o_speed_out, spd4(256, 256, 256, 356));
      repeat (3) @(posedge clk);
      #1;
      pulse_disarm();
      check("disarm_mid_state", o_state, 2'b00);
      check("disarm_mid_hold", o_speed_out, spd4(256, 256, 256, 356));
      wait_strobe(n);
      check("disarm_mid_cut", o_speed_out, 64'd0);

      // Asynchronous reset during a strobe cycle in RUN.
      pulse_arm();
      for (int k = 0; k < 3; k++) wait_strobe(n);
      pulse_cmd({4{16'd4000}});
      wait_strobe(n);
      check("ramp3_a", o_speed_out, {4{16'd356}});
      pulse_cmd({4{16'd4000}});
      wait_strobe(n);
      check("ramp3_b", o_speed_out, {4{16'd456}});
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_out", o_speed_out, 64'd0);
      check("async_rst_oe", o_speed_oe, 1'b0);
      check("async_rst_state", o_state, 2'b00);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("post_rst_state", o_state, 2'b00);
      wait_strobe(n);
      check("post_rst_period", n, 8);
      check("post_rst_out", o_speed_out, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
